serial_uart_endpoint: RTL and testbench
=======================================

# serial_uart_endpoint

Device-side endpoint for the processor's byte-wide serial port. It accepts bytes written by the processor into a TX FIFO and serializes them as 8N1 UART frames. It also deserializes incoming UART frames into an RX FIFO that the processor drains through its valid/read-enable handshake. It sits between the processor's serial_* ports and the board UART pins, replacing the bench's constant tie-offs.

## Interface

- CLKS_PER_BIT, 16, clock cycles per UART bit; must be ≥ 4 and even.
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; must be a power of two.

- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- cpu_wdata  in  8  byte from the processor; connects to serial_out.
- cpu_wren  in  1  processor write strobe; connects to serial_wren_out.
- cpu_ready  out  1  TX FIFO not full; connects to serial_ready_in.
- cpu_rdata  out  8  head of the RX FIFO; connects to serial_in.
- cpu_valid  out  1  RX FIFO not empty; connects to serial_valid_in.
- cpu_rden  in  1  processor read strobe; pops the RX FIFO; connects to serial_rden_out.
- uart_tx  out  1  serial line out; idles high.
- uart_rx  in  1  serial line in; asynchronous.
- rx_overrun  out  1  sticky; a received byte was dropped because the RX FIFO was full.
- rx_frame_err  out  1  sticky; a stop bit was sampled low.

## Operation

- **TX push:** when cpu_wren=1 and cpu_ready=1, cpu_wdata is written to the TX FIFO. When cpu_wren=1 and cpu_ready=0, the write is silently ignored.
- **TX FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** uart_tx=1. If the TX FIFO is not empty, pop the head into an 8-bit shift register and go to START.
- **START:** uart_tx=0 for CLKS_PER_BIT cycles.
- **DATA:** 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit index and a baud counter track position.
- **STOP:** uart_tx=1 for CLKS_PER_BIT cycles. On the last stop cycle, if the FIFO is not empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- **RX synchronizer:** uart_rx passes through a 2-flop synchronizer; the FSM sees rx_s.
- **RX FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** on rx_s=0, go to START and clear the baud counter.
- **START:** sample at CLKS_PER_BIT/2. If rx_s=1 it was a false start: go to IDLE and push nothing. Otherwise go to DATA.
- **DATA:** sample every CLKS_PER_BIT cycles (mid-bit), shifting LSB first, for 8 samples.
- **STOP:** sample at mid-bit.
  - Stop bit = 1: push the byte. If the FIFO is full and cpu_rden is not popping this same cycle, drop the byte and set rx_overrun.
  - Stop bit = 0: drop the byte and set rx_frame_err.
  - Either way, go to IDLE immediately after the sample (the second half of the stop bit is not waited out).
- **RX pop:** cpu_rden=1 with cpu_valid=1 pops. cpu_rden while empty is ignored. cpu_rdata shows the FIFO head (fall-through) and is forced to 8'h00 when cpu_valid=0.
- **FIFOs:** read/write pointers plus a count of width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop when non-empty: count unchanged, both operations happen.
  - On a full RX FIFO, a same-cycle pop makes room for the push.
  - On an empty TX FIFO, a same-cycle push and FSM pop cannot occur; the FSM sees the entry the next cycle.
- **Reset (including mid-frame):**
  - Both FIFOs empty, both FSMs in IDLE, stickies cleared.
  - Output values: uart_tx=1, cpu_ready=1, cpu_valid=0, cpu_rdata=8'h00, rx_overrun=0, rx_frame_err=0.
  - A partially sent frame is abandoned; the line is high in the cycle after reset is sampled.

## Timing

- cpu_ready and cpu_valid are derived from the registered FIFO counts; they update the cycle after a push or pop.
- **TX latency:** a write sampled at edge N into an idle, empty block drives uart_tx low starting after edge N+2.
- **TX frame length:** exactly 10×CLKS_PER_BIT cycles; back-to-back frames are contiguous.
- **TX capacity:** FIFO_DEPTH bytes in the FIFO plus 1 in the shifter.
- **RX latency:** cpu_valid rises 1 cycle after the stop-bit mid sample.
  - The stop-bit mid sample is 2 (synchronizer) + 9.5×CLKS_PER_BIT cycles after the falling start edge on uart_rx, ±1 cycle.
- Stickies are set on the cycle after the sample edge and are cleared only by reset.

## Test plan

- **Reset:** assert reset for 3 cycles mid-TX-frame -> next cycle uart_tx=1, cpu_ready=1, cpu_valid=0, cpu_rdata=00, and both stickies 0.
- **Single TX (CLKS_PER_BIT=16):** write 0x55 -> start bit low begins 2 cycles after the write and lasts 16 cycles; data bits 1,0,1,0,1,0,1,0; stop bit high; frame total 160 cycles; line then idles high.
- **TX full:** write 0xA0, 0xA1, … every cycle while idle -> exactly 5 bytes accepted (cpu_ready drops), the 6th is ignored, and 0xA0–0xA4 appear contiguously in order over 800 cycles.
- **Loopback:** tie uart_tx to uart_rx and write 0x48, 0x69 -> cpu_valid=1 with cpu_rdata=0x48; after a 1-cycle cpu_rden pulse, cpu_rdata=0x69; after a second pulse, cpu_valid=0 and cpu_rdata=00.
- **RX overrun:** drive 5 frames 0x01–0x05 with no reads -> rx_overrun=1 after the 5th stop sample; four reads return 0x01–0x04; rx_frame_err=0.
- **RX errors:** a 4-cycle low glitch on uart_rx pushes nothing and raises no flag. A frame of 0x3C with stop bit 0 -> rx_frame_err=1, cpu_valid stays 0, and a following good frame 0x7E is received normally.

Source files
------------

// File: rtl/serial_uart_endpoint.sv
// 8N1 UART endpoint between the processor serial port and the board UART pins.
// A TX FIFO feeds a serializer, and a deserializer fills an RX FIFO that the processor drains.
module serial_uart_endpoint #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] cpu_wdata,
   input  logic       cpu_wren,
   output logic       cpu_ready,
   output logic [7:0] cpu_rdata,
   output logic       cpu_valid,
   input  logic       cpu_rden,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   // TX path state
   logic [7:0]    tx_mem_q [FIFO_DEPTH];
   logic [7:0]    tx_mem_d [FIFO_DEPTH];
   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   uart_state_t   tx_state_q, tx_state_d;
   logic [BW-1:0] tx_baud_q, tx_baud_d;
   logic [2:0]    tx_idx_q, tx_idx_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_line_q, tx_line_d;
   logic          tx_push_s, tx_pop_s;

   // RX path state
   logic [7:0]    rx_mem_q [FIFO_DEPTH];
   logic [7:0]    rx_mem_d [FIFO_DEPTH];
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   uart_state_t   rx_state_q, rx_state_d;
   logic [BW-1:0] rx_baud_q, rx_baud_d;
   logic [2:0]    rx_idx_q, rx_idx_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
   logic          rx_overrun_q, rx_overrun_d, rx_frame_err_q, rx_frame_err_d;
   logic          rx_push_s, rx_pop_s;

   assign cpu_ready    = (tx_cnt_q != FULL_CNT);
   assign cpu_valid    = (rx_cnt_q != '0);
   assign cpu_rdata    = cpu_valid ? rx_mem_q[rx_rp_q] : 8'h00;
   assign uart_tx      = tx_line_q;
   assign rx_overrun   = rx_overrun_q;
   assign rx_frame_err = rx_frame_err_q;

   // TX FIFO and serializer; the line register lags the state by one cycle.
   always_comb begin
      tx_push_s  = cpu_wren && (tx_cnt_q != FULL_CNT);
      tx_pop_s   = 1'b0;
      tx_state_d = tx_state_q;
      tx_baud_d  = tx_baud_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_line_d  = 1'b1;
      tx_mem_d   = tx_mem_q;
      case (tx_state_q)
         ST_IDLE: begin
            tx_line_d = 1'b1;
            if (tx_cnt_q != '0) begin
               tx_pop_s   = 1'b1;
               tx_shift_d = tx_mem_q[tx_rp_q];
               tx_baud_d  = '0;
               tx_state_d = ST_START;
            end else begin
               tx_state_d = ST_IDLE;
            end
         end
         ST_START: begin
            tx_line_d = 1'b0;
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d  = '0;
               tx_idx_d   = 3'd0;
               tx_state_d = ST_DATA;
            end else begin
               tx_baud_d = tx_baud_q + BW'(1);
            end
         end
         ST_DATA: begin
            tx_line_d = tx_shift_q[0];
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d  = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_idx_q == 3'd7) begin
                  tx_state_d = ST_STOP;
               end else begin
                  tx_idx_d = tx_idx_q + 3'd1;
               end
            end else begin
               tx_baud_d = tx_baud_q + BW'(1);
            end
         end
         ST_STOP: begin
            tx_line_d = 1'b1;
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d = '0;
               // Chain straight into the next start bit so queued frames are contiguous.
               if (tx_cnt_q != '0) begin
                  tx_pop_s   = 1'b1;
                  tx_shift_d = tx_mem_q[tx_rp_q];
                  tx_state_d = ST_START;
               end else begin
                  tx_state_d = ST_IDLE;
               end
            end else begin
               tx_baud_d = tx_baud_q + BW'(1);
            end
         end
         default: begin
            tx_state_d = ST_IDLE;
         end
      endcase

      if (tx_push_s) begin
         tx_mem_d[tx_wp_q] = cpu_wdata;
         tx_wp_d = tx_wp_q + AW'(1);
      end else begin
         tx_wp_d = tx_wp_q;
      end
      if (tx_pop_s) begin
         tx_rp_d = tx_rp_q + AW'(1);
      end else begin
         tx_rp_d = tx_rp_q;
      end
      case ({tx_push_s, tx_pop_s})
         2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
         2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
         default: tx_cnt_d = tx_cnt_q;
      endcase
   end

   // RX synchronizer, deserializer, FIFO and sticky error flags.
   always_comb begin
      rx_meta_d      = uart_rx;
      rx_sync_d      = rx_meta_q;
      rx_pop_s       = cpu_rden && (rx_cnt_q != '0);
      rx_push_s      = 1'b0;
      rx_state_d     = rx_state_q;
      rx_baud_d      = rx_baud_q;
      rx_idx_d       = rx_idx_q;
      rx_shift_d     = rx_shift_q;
      rx_overrun_d   = rx_overrun_q;
      rx_frame_err_d = rx_frame_err_q;
      rx_mem_d       = rx_mem_q;
      case (rx_state_q)
         ST_IDLE: begin
            if (!rx_sync_q) begin
               rx_baud_d  = '0;
               rx_state_d = ST_START;
            end else begin
               rx_state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (rx_baud_q == BAUD_HALF) begin
               rx_baud_d  = '0;
               rx_idx_d   = 3'd0;
               rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end else begin
               rx_baud_d = rx_baud_q + BW'(1);
            end
         end
         ST_DATA: begin
            if (rx_baud_q == BAUD_LAST) begin
               rx_baud_d  = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_idx_q == 3'd7) begin
                  rx_state_d = ST_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end else begin
               rx_baud_d = rx_baud_q + BW'(1);
            end
         end
         ST_STOP: begin
            if (rx_baud_q == BAUD_LAST) begin
               rx_baud_d  = '0;
               rx_state_d = ST_IDLE;
               // A same-cycle pop frees the slot a full FIFO would otherwise refuse.
               if (!rx_sync_q) begin
                  rx_frame_err_d = 1'b1;
               end else if ((rx_cnt_q != FULL_CNT) || rx_pop_s) begin
                  rx_push_s = 1'b1;
               end else begin
                  rx_overrun_d = 1'b1;
               end
            end else begin
               rx_baud_d = rx_baud_q + BW'(1);
            end
         end
         default: begin
            rx_state_d = ST_IDLE;
         end
      endcase

      if (rx_push_s) begin
         rx_mem_d[rx_wp_q] = rx_shift_q;
         rx_wp_d = rx_wp_q + AW'(1);
      end else begin
         rx_wp_d = rx_wp_q;
      end
      if (rx_pop_s) begin
         rx_rp_d = rx_rp_q + AW'(1);
      end else begin
         rx_rp_d = rx_rp_q;
      end
      case ({rx_push_s, rx_pop_s})
         2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
         2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
         default: rx_cnt_d = rx_cnt_q;
      endcase
   end

   // State registers for both directions.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_mem_q       <= '{default: 8'h00};
         tx_wp_q        <= '0;
         tx_rp_q        <= '0;
         tx_cnt_q       <= '0;
         tx_state_q     <= ST_IDLE;
         tx_baud_q      <= '0;
         tx_idx_q       <= 3'd0;
         tx_shift_q     <= 8'h00;
         tx_line_q      <= 1'b1;
         rx_mem_q       <= '{default: 8'h00};
         rx_wp_q        <= '0;
         rx_rp_q        <= '0;
         rx_cnt_q       <= '0;
         rx_state_q     <= ST_IDLE;
         rx_baud_q      <= '0;
         rx_idx_q       <= 3'd0;
         rx_shift_q     <= 8'h00;
         rx_meta_q      <= 1'b1;
         rx_sync_q      <= 1'b1;
         rx_overrun_q   <= 1'b0;
         rx_frame_err_q <= 1'b0;
      end else begin
         tx_mem_q       <= tx_mem_d;
         tx_wp_q        <= tx_wp_d;
         tx_rp_q        <= tx_rp_d;
         tx_cnt_q       <= tx_cnt_d;
         tx_state_q     <= tx_state_d;
         tx_baud_q      <= tx_baud_d;
         tx_idx_q       <= tx_idx_d;
         tx_shift_q     <= tx_shift_d;
         tx_line_q      <= tx_line_d;
         rx_mem_q       <= rx_mem_d;
         rx_wp_q        <= rx_wp_d;
         rx_rp_q        <= rx_rp_d;
         rx_cnt_q       <= rx_cnt_d;
         rx_state_q     <= rx_state_d;
         rx_baud_q      <= rx_baud_d;
         rx_idx_q       <= rx_idx_d;
         rx_shift_q     <= rx_shift_d;
         rx_meta_q      <= rx_meta_d;
         rx_sync_q      <= rx_sync_d;
         rx_overrun_q   <= rx_overrun_d;
         rx_frame_err_q <= rx_frame_err_d;
      end
   end

endmodule

// File: tb/tb_serial_uart_endpoint.sv
// Directed bench for serial_uart_endpoint: TX/RX frame tables plus hand-written
// sequences for FIFO-full, loopback, overrun, reset mid-frame and RX error cases.
module tb_serial_uart_endpoint;

   localparam int C = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] cpu_wdata;
   logic       cpu_wren;
   logic       cpu_ready;
   logic [7:0] cpu_rdata;
   logic       cpu_valid;
   logic       cpu_rden;
   logic       uart_tx;
   logic       uart_rx;
   logic       rx_overrun;
   logic       rx_frame_err;
   logic       rx_drv;
   logic       loop_en;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n;
   int t;
   logic line_hist [0:16383];

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } tx_vec_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_rdata;
      logic       exp_ferr;
   } rx_vec_t;

   tx_vec_t tx_tab [3];
   rx_vec_t rx_tab [5];

   assign uart_rx = loop_en ? uart_tx : rx_drv;

   serial_uart_endpoint #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .cpu_wdata    (cpu_wdata),
      .cpu_wren     (cpu_wren),
      .cpu_ready    (cpu_ready),
      .cpu_rdata    (cpu_rdata),
      .cpu_valid    (cpu_valid),
      .cpu_rden     (cpu_rden),
      .uart_tx      (uart_tx),
      .uart_rx      (uart_rx),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Line value during the cycle that follows edge number cyc.
   always @(negedge clock) begin
      if (cyc < 16384) line_hist[cyc] = uart_tx;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic frame_check(input string name, input int base, input logic [9:0] exp_frame);
      int hits = 0;
      for (int k = 0; k < 10; k++) begin
         for (int m = 0; m < C; m++) begin
            if (line_hist[base + C * k + m] === exp_frame[k]) hits++;
         end
      end
      check(name, hits, 10 * C);
   endtask

   task automatic high_check(input string name, input int base, input int len);
      int hits = 0;
      for (int j = 0; j < len; j++) begin
         if (line_hist[base + j] === 1'b1) hits++;
      end
      check(name, hits, len);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      rx_drv = 1'b0;
      repeat (C) step();
      for (int k = 0; k < 8; k++) begin
         rx_drv = d[k];
         repeat (C) step();
      end
      rx_drv = stop;
      repeat (C) step();
      rx_drv = 1'b1;
      repeat (2 * C) step();
   endtask

   task automatic pop_pulse();
      cpu_rden = 1'b1;
      step();
      cpu_rden = 1'b0;
   endtask

   initial begin
      tx_tab[0] = '{8'h55, 10'h2AA};
      tx_tab[1] = '{8'h0F, 10'h21E};
      tx_tab[2] = '{8'hC3, 10'h386};
      rx_tab[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
      rx_tab[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
      rx_tab[2] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1};
      rx_tab[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
      rx_tab[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1};

      reset = 1'b1; cpu_wdata = 8'h00; cpu_wren = 1'b0; cpu_rden = 1'b0;
      rx_drv = 1'b1; loop_en = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      check("rst_uart_tx", uart_tx, 1);
      check("rst_ready", cpu_ready, 1);
      check("rst_valid", cpu_valid, 0);
      check("rst_rdata", cpu_rdata, 8'h00);
      check("rst_overrun", rx_overrun, 0);
      check("rst_frame_err", rx_frame_err, 0);
      repeat (4) step();

      // Single TX frames: start bit begins two cycles after the write edge.
      for (int i = 0; i < 3; i++) begin
         cpu_wdata = tx_tab[i].data; cpu_wren = 1'b1;
         step();
         cpu_wren = 1'b0; n = cyc;
         repeat (175) step();
         high_check($sformatf("tx%0d_pre_idle", i), n, 2);
         frame_check($sformatf("tx%0d_frame", i), n + 2, tx_tab[i].frame);
         high_check($sformatf("tx%0d_post_idle", i), n + 162, 12);
      end

      // TX full: five bytes accepted (four in FIFO, one in the shifter).
      for (int i = 0; i < 6; i++) begin
         cpu_wdata = 8'hA0 + i[7:0]; cpu_wren = 1'b1;
         step();
         if (i == 0) n = cyc;
         if (i == 3) check("txfull_ready_after4", cpu_ready, 1);
         if (i == 4) check("txfull_ready_after5", cpu_ready, 0);
      end
      cpu_wren = 1'b0;
      check("txfull_ready_after6", cpu_ready, 0);
      repeat (820) step();
      for (int f = 0; f < 5; f++) begin
         frame_check($sformatf("txfull_frame%0d", f), n + 2 + 10 * C * f,
                     {1'b1, 8'hA0 + f[7:0], 1'b0});
      end
      high_check("txfull_idle_after", n + 2 + 50 * C, 16);
      check("txfull_ready_end", cpu_ready, 1);

      // Loopback of two back-to-back frames.
      loop_en = 1'b1;
      cpu_wdata = 8'h48; cpu_wren = 1'b1;
      step();
      n = cyc;
      cpu_wdata = 8'h69;
      step();
      cpu_wren = 1'b0;
      t = 0;
      while (!cpu_valid && t < 400) begin
         step();
         t++;
      end
      check("lb_valid_first", cpu_valid, 1);
      check("lb_latency_window", (cyc >= n + 155) && (cyc <= n + 159), 1);
      check("lb_rdata_first", cpu_rdata, 8'h48);
      repeat (200) step();
      pop_pulse();
      check("lb_valid_second", cpu_valid, 1);
      check("lb_rdata_second", cpu_rdata, 8'h69);
      pop_pulse();
      check("lb_valid_empty", cpu_valid, 0);
      check("lb_rdata_empty", cpu_rdata, 8'h00);
      check("lb_overrun", rx_overrun, 0);
      check("lb_frame_err", rx_frame_err, 0);
      loop_en = 1'b0;
      repeat (4) step();

      // RX overrun: fifth frame dropped with no reads.
      for (int i = 0; i < 4; i++) send_frame(8'h01 + i[7:0], 1'b1);
      check("ovr_before_fifth", rx_overrun, 0);
      send_frame(8'h05, 1'b1);
      check("ovr_after_fifth", rx_overrun, 1);
      check("ovr_frame_err", rx_frame_err, 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovr_read%0d_valid", i), cpu_valid, 1);
         check($sformatf("ovr_read%0d_data", i), cpu_rdata, 8'h01 + i[7:0]);
         pop_pulse();
      end
      check("ovr_empty_valid", cpu_valid, 0);
      pop_pulse();
      check("ovr_pop_empty_ignored", cpu_valid, 0);
      check("ovr_pop_empty_rdata", cpu_rdata, 8'h00);

      // Reset mid-frame with RX data pending and the overrun flag set.
      send_frame(8'h11, 1'b1);
      check("prerst_valid", cpu_valid, 1);
      cpu_wdata = 8'h00; cpu_wren = 1'b1;
      step();
      cpu_wren = 1'b0;
      repeat (40) step();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      check("midrst_uart_tx", uart_tx, 1);
      check("midrst_ready", cpu_ready, 1);
      check("midrst_valid", cpu_valid, 0);
      check("midrst_rdata", cpu_rdata, 8'h00);
      check("midrst_overrun", rx_overrun, 0);
      check("midrst_frame_err", rx_frame_err, 0);
      n = cyc;
      repeat (201) step();
      high_check("midrst_abandoned", n, 200);

      // Short low glitch is a false start.
      rx_drv = 1'b0;
      repeat (4) step();
      rx_drv = 1'b1;
      repeat (40) step();
      check("glitch_valid", cpu_valid, 0);
      check("glitch_frame_err", rx_frame_err, 0);
      check("glitch_overrun", rx_overrun, 0);

      // RX frame table, including a bad stop bit and recovery.
      for (int i = 0; i < 5; i++) begin
         send_frame(rx_tab[i].data, rx_tab[i].stop);
         check($sformatf("rx%0d_valid", i), cpu_valid, rx_tab[i].exp_valid);
         check($sformatf("rx%0d_rdata", i), cpu_rdata, rx_tab[i].exp_rdata);
         check($sformatf("rx%0d_frame_err", i), rx_frame_err, rx_tab[i].exp_ferr);
         check($sformatf("rx%0d_overrun", i), rx_overrun, 0);
         if (rx_tab[i].exp_valid) pop_pulse();
         check($sformatf("rx%0d_drained", i), cpu_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
